time_set_controller: RTL and testbench

Sequencing controller for the hh:mm:ss timekeeping datapath. It gates counting, lets the user edit hours, minutes and seconds with three debounced push-button pulses, and commits the edited time to the datapath with a one-cycle load strobe. It sits between the button conditioning logic and the timekeeping counters. It also drives the blink mask consumed by the 7-segment display driver.

---
 rtl/clock_ctrl_pkg.sv | 52 +++++
 rtl/time_set_controller_if.sv | 34 +++
 rtl/wrap_field.sv | 32 +++
 rtl/time_set_controller.sv | 148 ++++++++++++++
 tb/tb_time_set_controller.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/clock_ctrl_pkg.sv
// Shared types and constants for the time-set controller.
//   state_t    : controller states (COMMIT is transient, reported as mode 3)
//   HOUR_MAX / MINSEC_MAX : inclusive upper bounds of the edited fields
//   BLINK_*    : bit positions of each field in blink_mask
package clock_ctrl_pkg;

  localparam int unsigned FIELD_W = 8;
  localparam int unsigned MASK_W  = 3;
  localparam int unsigned MODE_W  = 2;

  localparam logic [FIELD_W-1:0] HOUR_MAX   = 8'd23;
  localparam logic [FIELD_W-1:0] MINSEC_MAX = 8'd59;

  localparam int unsigned BLINK_H = 2;
  localparam int unsigned BLINK_M = 1;
  localparam int unsigned BLINK_S = 0;

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_S  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  // Externally visible mode code for a state.
  function automatic logic [MODE_W-1:0] mode_of(input state_t s);
    logic [MODE_W-1:0] m;
    case (s)
      ST_SET_H:  m = 2'd1;
      ST_SET_M:  m = 2'd2;
      ST_SET_S:  m = 2'd3;
      ST_COMMIT: m = 2'd3;
      default:   m = 2'd0;
    endcase
    return m;
  endfunction

  // Blink mask: selected field's bit follows the blink phase.
  function automatic logic [MASK_W-1:0] mask_for(input state_t s, input logic ph);
    logic [MASK_W-1:0] m;
    m = '0;
    case (s)
      ST_SET_H: m[BLINK_H] = ph;
      ST_SET_M: m[BLINK_M] = ph;
      ST_SET_S: m[BLINK_S] = ph;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/time_set_controller_if.sv
// Bundle between button/datapath side (master) and the controller (slave).
//   master drives tick_1hz, btn_*, cur_*; slave drives run, load, load_*,
//   blink_mask and mode.
interface time_set_controller_if;
  import clock_ctrl_pkg::*;

  logic               tick_1hz;
  logic               btn_mode;
  logic               btn_up;
  logic               btn_down;
  logic [FIELD_W-1:0] cur_hours;
  logic [FIELD_W-1:0] cur_minutes;
  logic [FIELD_W-1:0] cur_seconds;
  logic               run;
  logic               load;
  logic [FIELD_W-1:0] load_hours;
  logic [FIELD_W-1:0] load_minutes;
  logic [FIELD_W-1:0] load_seconds;
  logic [MASK_W-1:0]  blink_mask;
  logic [MODE_W-1:0]  mode;

  modport master (
    output tick_1hz, btn_mode, btn_up, btn_down,
    output cur_hours, cur_minutes, cur_seconds,
    input  run, load, load_hours, load_minutes, load_seconds, blink_mask, mode
  );

  modport slave (
    input  tick_1hz, btn_mode, btn_up, btn_down,
    input  cur_hours, cur_minutes, cur_seconds,
    output run, load, load_hours, load_minutes, load_seconds, blink_mask, mode
  );

endinterface

// File: rtl/wrap_field.sv
// One editable time field with wrap-around over 0..MAX.
//   capture/cap_val : load the live value unmodified
//   up / down       : step the field; both together leave it unchanged
//   q               : current field value
// Values above MAX (only reachable via capture) go to 0 on up, MAX on down.
module wrap_field
  import clock_ctrl_pkg::*;
#(
  parameter logic [FIELD_W-1:0] MAX = MINSEC_MAX
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               capture,
  input  logic [FIELD_W-1:0] cap_val,
  input  logic               up,
  input  logic               down,
  output logic [FIELD_W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (capture) begin
      q <= cap_val;
    end else if (up && !down) begin
      q <= (q >= MAX) ? '0 : q + FIELD_W'(1);
    end else if (down && !up) begin
      q <= (q == '0 || q > MAX) ? MAX : q - FIELD_W'(1);
    end
  end

endmodule

// File: rtl/time_set_controller.sv
// Edit/commit sequencer for the hh:mm:ss datapath.
//   clk, rst : system clock, async active-high reset
//   bus      : slave side of time_set_controller_if (buttons, tick, live
//              time in; run, load strobe, edit registers, blink mask, mode out)
// RUN -> SET_H -> SET_M -> SET_S -> COMMIT -> RUN on btn_mode; an idle
// SET state falls back to RUN after TIMEOUT_S ticks without loading.
module time_set_controller
  import clock_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_S = 30
) (
  input  logic                 clk,
  input  logic                 rst,
  time_set_controller_if.slave bus
);

  localparam int unsigned    TW      = $clog2(TIMEOUT_S + 1);
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_S - 1);

  state_t              state;
  logic                run_q;
  logic                load_q;
  logic [MODE_W-1:0]   mode_q;
  logic [MASK_W-1:0]   mask_q;
  logic                phase;
  logic [TW-1:0]       to_cnt;

  logic                in_set;
  logic                any_btn;
  logic                phase_tgl;
  logic                edit_ok;
  state_t              set_next;

  assign in_set    = (state == ST_SET_H) || (state == ST_SET_M) || (state == ST_SET_S);
  assign any_btn   = bus.btn_mode | bus.btn_up | bus.btn_down;
  assign phase_tgl = phase ^ bus.tick_1hz;
  // btn_mode wins over up/down in the same cycle.
  assign edit_ok   = in_set && !bus.btn_mode;

  // Successor of the current SET state on btn_mode.
  always_comb begin
    set_next = ST_COMMIT;
    case (state)
      ST_SET_H: set_next = ST_SET_M;
      ST_SET_M: set_next = ST_SET_S;
      default:  set_next = ST_COMMIT;
    endcase
  end

  // State, timeout, blink phase and all status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_RUN;
      run_q  <= 1'b1;
      load_q <= 1'b0;
      mode_q <= '0;
      mask_q <= '0;
      phase  <= 1'b0;
      to_cnt <= '0;
    end else begin
      load_q <= 1'b0;
      case (state)
        ST_RUN: begin
          if (bus.btn_mode) begin
            state  <= ST_SET_H;
            run_q  <= 1'b0;
            mode_q <= mode_of(ST_SET_H);
            mask_q <= '0;
            phase  <= 1'b0;
            to_cnt <= '0;
          end
        end
        ST_SET_H, ST_SET_M, ST_SET_S: begin
          if (bus.btn_mode) begin
            to_cnt <= '0;
            state  <= set_next;
            mode_q <= mode_of(set_next);
            if (set_next == ST_COMMIT) begin
              load_q <= 1'b1;
              phase  <= 1'b0;
              mask_q <= '0;
            end else begin
              phase  <= phase_tgl;
              mask_q <= mask_for(set_next, phase_tgl);
            end
          end else if (bus.tick_1hz && !any_btn && to_cnt == TO_LAST) begin
            // Abandon the edit; datapath keeps its own value.
            state  <= ST_RUN;
            run_q  <= 1'b1;
            mode_q <= '0;
            mask_q <= '0;
            phase  <= 1'b0;
            to_cnt <= '0;
          end else begin
            to_cnt <= any_btn ? '0 : to_cnt + TW'(bus.tick_1hz);
            phase  <= phase_tgl;
            mask_q <= mask_for(state, phase_tgl);
          end
        end
        default: begin
          // COMMIT: one cycle, buttons ignored.
          state  <= ST_RUN;
          run_q  <= 1'b1;
          mode_q <= '0;
          mask_q <= '0;
          phase  <= 1'b0;
          to_cnt <= '0;
        end
      endcase
    end
  end

  wrap_field #(.MAX(HOUR_MAX)) u_hours (
    .clk     (clk),
    .rst     (rst),
    .capture (state == ST_RUN && bus.btn_mode),
    .cap_val (bus.cur_hours),
    .up      (edit_ok && state == ST_SET_H && bus.btn_up),
    .down    (edit_ok && state == ST_SET_H && bus.btn_down),
    .q       (bus.load_hours)
  );

  wrap_field #(.MAX(MINSEC_MAX)) u_minutes (
    .clk     (clk),
    .rst     (rst),
    .capture (state == ST_RUN && bus.btn_mode),
    .cap_val (bus.cur_minutes),
    .up      (edit_ok && state == ST_SET_M && bus.btn_up),
    .down    (edit_ok && state == ST_SET_M && bus.btn_down),
    .q       (bus.load_minutes)
  );

  wrap_field #(.MAX(MINSEC_MAX)) u_seconds (
    .clk     (clk),
    .rst     (rst),
    .capture (state == ST_RUN && bus.btn_mode),
    .cap_val (bus.cur_seconds),
    .up      (edit_ok && state == ST_SET_S && bus.btn_up),
    .down    (edit_ok && state == ST_SET_S && bus.btn_down),
    .q       (bus.load_seconds)
  );

  assign bus.run        = run_q;
  assign bus.load       = load_q;
  assign bus.mode       = mode_q;
  assign bus.blink_mask = mask_q;

endmodule

// File: tb/tb_time_set_controller.sv
// Scoreboard bench for time_set_controller (TIMEOUT_S = 3).
module tb_time_set_controller;

  typedef struct packed {
    logic       run;
    logic       load;
    logic [1:0] mode;
    logic [2:0] mask;
    logic [7:0] h;
    logic [7:0] m;
    logic [7:0] s;
  } snap_t;

  logic clk;
  logic rst;
  logic obs_req;

  int checks;
  int failures;

  snap_t        snap_q[$];
  string        name_q[$];
  logic [23:0]  load_q[$];
  snap_t        exp_s;
  snap_t        act_s;
  logic [23:0]  exp_l;
  string        nm;

  time_set_controller_if bus();

  time_set_controller #(.TIMEOUT_S(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares state snapshots on request and every load strobe.
  always @(negedge clk) begin
    if (obs_req) begin
      checks++;
      act_s = {bus.run, bus.load, bus.mode, bus.blink_mask,
               bus.load_hours, bus.load_minutes, bus.load_seconds};
      if (snap_q.size() == 0) begin
        failures++;
        $display("FAIL snapshot: no expectation queued, actual=%h", act_s);
      end else begin
        exp_s = snap_q.pop_front();
        nm    = name_q.pop_front();
        if (act_s !== exp_s) begin
          failures++;
          $display("FAIL %s: actual run=%b load=%b mode=%0d mask=%b t=%0d:%0d:%0d required run=%b load=%b mode=%0d mask=%b t=%0d:%0d:%0d",
                   nm, act_s.run, act_s.load, act_s.mode, act_s.mask, act_s.h, act_s.m, act_s.s,
                   exp_s.run, exp_s.load, exp_s.mode, exp_s.mask, exp_s.h, exp_s.m, exp_s.s);
        end
      end
    end
    if (bus.load !== 1'b0) begin
      checks++;
      if (load_q.size() == 0) begin
        failures++;
        $display("FAIL load_strobe: unexpected load=%b with %0d:%0d:%0d, required no load",
                 bus.load, bus.load_hours, bus.load_minutes, bus.load_seconds);
      end else begin
        exp_l = load_q.pop_front();
        if ({bus.load_hours, bus.load_minutes, bus.load_seconds} !== exp_l) begin
          failures++;
          $display("FAIL load_value: actual %0d:%0d:%0d required %0d:%0d:%0d",
                   bus.load_hours, bus.load_minutes, bus.load_seconds,
                   exp_l[23:16], exp_l[15:8], exp_l[7:0]);
        end
      end
    end
  end

  task automatic pulse(input logic m, input logic u, input logic d, input logic t);
    bus.btn_mode = m;
    bus.btn_up   = u;
    bus.btn_down = d;
    bus.tick_1hz = t;
    @(posedge clk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.tick_1hz = 1'b0;
  endtask

  task automatic expect_snap(input string name, input logic r, input logic l,
                             input logic [1:0] md, input logic [2:0] mk,
                             input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    snap_t e;
    e = {r, l, md, mk, h, mi, s};
    snap_q.push_back(e);
    name_q.push_back(name);
    obs_req = 1'b1;
    @(negedge clk);
    #1;
    obs_req = 1'b0;
  endtask

  task automatic set_cur(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    bus.cur_hours   = h;
    bus.cur_minutes = m;
    bus.cur_seconds = s;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    obs_req  = 1'b0;
    rst      = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_up   = 1'b0;
    bus.btn_down = 1'b0;
    bus.tick_1hz = 1'b0;
    set_cur(8'd0, 8'd0, 8'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    expect_snap("reset_state", 1, 0, 2'd0, 3'b000, 8'd0, 8'd0, 8'd0);

    // Main edit/commit flow: 12:34:56 -> 15:33:56
    set_cur(8'd12, 8'd34, 8'd56);
    pulse(1, 0, 0, 0);
    expect_snap("capture", 0, 0, 2'd1, 3'b000, 8'd12, 8'd34, 8'd56);
    for (int i = 0; i < 3; i++) pulse(0, 1, 0, 0);
    expect_snap("hours_up3", 0, 0, 2'd1, 3'b000, 8'd15, 8'd34, 8'd56);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    expect_snap("min_down", 0, 0, 2'd2, 3'b000, 8'd15, 8'd33, 8'd56);
    pulse(1, 0, 0, 0);
    expect_snap("set_s", 0, 0, 2'd3, 3'b000, 8'd15, 8'd33, 8'd56);
    load_q.push_back({8'd15, 8'd33, 8'd56});
    pulse(1, 0, 0, 0);
    expect_snap("commit", 0, 1, 2'd3, 3'b000, 8'd15, 8'd33, 8'd56);
    // Buttons during COMMIT are ignored.
    pulse(1, 1, 0, 0);
    expect_snap("after_commit", 1, 0, 2'd0, 3'b000, 8'd15, 8'd33, 8'd56);

    // Wrap boundaries: 23:00:59 -> 00:59:00
    set_cur(8'd23, 8'd0, 8'd59);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    expect_snap("hour_wrap_up", 0, 0, 2'd1, 3'b000, 8'd0, 8'd0, 8'd59);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    expect_snap("min_wrap_down", 0, 0, 2'd2, 3'b000, 8'd0, 8'd59, 8'd59);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    expect_snap("sec_wrap_up", 0, 0, 2'd3, 3'b000, 8'd0, 8'd59, 8'd0);
    load_q.push_back({8'd0, 8'd59, 8'd0});
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 0);
    expect_snap("wrap_run", 1, 0, 2'd0, 3'b000, 8'd0, 8'd59, 8'd0);

    // Out-of-range captured hours
    set_cur(8'd30, 8'd0, 8'd0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    expect_snap("oor_up", 0, 0, 2'd1, 3'b000, 8'd0, 8'd0, 8'd0);
    load_q.push_back({8'd0, 8'd0, 8'd0});
    for (int i = 0; i < 3; i++) pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 1, 0);
    expect_snap("oor_down", 0, 0, 2'd1, 3'b000, 8'd23, 8'd0, 8'd0);
    pulse(0, 1, 1, 0);
    expect_snap("up_down_same", 0, 0, 2'd1, 3'b000, 8'd23, 8'd0, 8'd0);
    pulse(1, 1, 0, 0);
    expect_snap("mode_over_up", 0, 0, 2'd2, 3'b000, 8'd23, 8'd0, 8'd0);
    load_q.push_back({8'd23, 8'd0, 8'd0});
    pulse(1, 0, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 0);
    expect_snap("oor_run", 1, 0, 2'd0, 3'b000, 8'd23, 8'd0, 8'd0);

    // Timeout, blink and count restart
    set_cur(8'd1, 8'd2, 8'd3);
    pulse(1, 0, 0, 0);
    pulse(0, 0, 0, 1);
    expect_snap("blink_h_on", 0, 0, 2'd1, 3'b100, 8'd1, 8'd2, 8'd3);
    pulse(0, 0, 0, 1);
    expect_snap("blink_h_off", 0, 0, 2'd1, 3'b000, 8'd1, 8'd2, 8'd3);
    pulse(0, 1, 0, 0);
    pulse(0, 0, 0, 1);
    expect_snap("restart_tick", 0, 0, 2'd1, 3'b100, 8'd2, 8'd2, 8'd3);
    pulse(1, 0, 0, 0);
    expect_snap("blink_m_carry", 0, 0, 2'd2, 3'b010, 8'd2, 8'd2, 8'd3);
    pulse(0, 0, 0, 1);
    pulse(0, 0, 0, 1);
    expect_snap("blink_m_on", 0, 0, 2'd2, 3'b010, 8'd2, 8'd2, 8'd3);
    pulse(0, 0, 0, 1);
    expect_snap("timeout_run", 1, 0, 2'd0, 3'b000, 8'd2, 8'd2, 8'd3);

    // Reset mid-SET_M with edits pending
    set_cur(8'd10, 8'd20, 8'd30);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    expect_snap("pre_reset", 0, 0, 2'd2, 3'b000, 8'd11, 8'd21, 8'd30);
    rst = 1'b1;
    expect_snap("mid_reset", 1, 0, 2'd0, 3'b000, 8'd0, 8'd0, 8'd0);
    #1 rst = 1'b0;
    repeat (2) pulse(0, 0, 0, 0);
    expect_snap("post_reset", 1, 0, 2'd0, 3'b000, 8'd0, 8'd0, 8'd0);

    repeat (3) @(posedge clk);
    checks++;
    if (load_q.size() != 0) begin
      failures++;
      $display("FAIL load_pending: actual %0d loads not seen, required 0", load_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
